dec_onehot_scan: RTL and testbench

Parametrised, registered N-to-OUTS one-hot decoder with built-in scan sequencing. It is the general successor to the fixed 4-to-16 combinational decoder. It drives one-hot select lines for LED/7-segment digit multiplexing and register-bank enables. It either decodes a handshaked select value or autonomously rotates the active line at a programmable dwell rate.

---
 rtl/dec_onehot_scan_pkg.sv | 16 +
 rtl/dec_onehot_scan_enc.sv | 21 ++
 rtl/dec_onehot_scan.sv | 134 +++++++++++++
 tb/tb_dec_onehot_scan.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_onehot_scan_pkg.sv
// Shared types and helpers for the one-hot scan decoder.
// Mode encodings and dwell counter sizing.
package dec_onehot_scan_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE      = 2'b00,
        MODE_DECODE    = 2'b01,
        MODE_SCAN_UP   = 2'b10,
        MODE_SCAN_DOWN = 2'b11
    } mode_e;

    function automatic int cnt_width(input int dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/dec_onehot_scan_enc.sv
// Combinational index to one-hot encoder with range check.
// Out-of-range indices produce an all-zero vector.
module onehot_enc #(
    parameter int N    = 4,
    parameter int OUTS = 16
) (
    input  logic [N-1:0]    idx,
    output logic [OUTS-1:0] oh,
    output logic            range_err
);

    always_comb begin
        oh = '0;
        for (int i = 0; i < OUTS; i++) begin
            oh[i] = (idx == N'(i));
        end
    end

    assign range_err = ({1'b0, idx} >= (N+1)'(OUTS));

endmodule

// File: rtl/dec_onehot_scan.sv
// Registered one-hot decoder with autonomous up/down scan.
// One encoder is shared by the decode and scan paths.
module dec_onehot_scan #(
    parameter int N          = 4,
    parameter int OUTS       = 16,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [1:0]      mode,
    input  logic [N-1:0]    sel,
    input  logic            sel_valid,
    output logic            sel_ready,
    output logic [OUTS-1:0] out,
    output logic [N-1:0]    idx,
    output logic            step,
    output logic            err
);

    import dec_onehot_scan_pkg::*;

    localparam int CW = cnt_width(DWELL);

    mode_e           mode_s;
    logic [OUTS-1:0] oh_q, oh_d;
    logic [N-1:0]    idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            scan_q, scan_d;
    logic            step_q, step_d;
    logic            err_q, err_d;

    logic            is_scan;
    logic            entering;
    logic            at_end;
    logic            adv;
    logic [N-1:0]    idx_nxt;
    logic [N-1:0]    enc_in;
    logic [OUTS-1:0] enc_oh;
    logic            enc_err;

    assign mode_s   = mode_e'(mode);
    assign is_scan  = mode[1];
    // The count restarts only when arriving from a non-scan mode.
    assign entering = is_scan & ~scan_q;
    assign at_end   = (cnt_q == CW'(DWELL - 1));
    assign adv      = is_scan & ~entering & at_end;

    always_comb begin
        idx_nxt = idx_q;
        if (adv) begin
            if (mode_s == MODE_SCAN_DOWN) begin
                idx_nxt = (idx_q == '0) ? N'(OUTS - 1)
                                        : idx_q - N'(1);
            end else begin
                idx_nxt = (idx_q == N'(OUTS - 1)) ? '0
                                                   : idx_q + N'(1);
            end
        end
    end

    assign enc_in = is_scan ? idx_nxt : sel;

    onehot_enc #(
        .N    (N),
        .OUTS (OUTS)
    ) u_enc (
        .idx       (enc_in),
        .oh        (enc_oh),
        .range_err (enc_err)
    );

    always_comb begin
        oh_d   = oh_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        scan_d = scan_q;
        step_d = 1'b0;
        err_d  = 1'b0;
        if (en) begin
            scan_d = is_scan;
            unique case (1'b1)
                (mode_s == MODE_IDLE): begin
                    oh_d  = '0;
                    cnt_d = '0;
                end
                (mode_s == MODE_DECODE): begin
                    if (sel_valid) begin
                        if (enc_err) begin
                            oh_d  = '0;
                            err_d = 1'b1;
                        end else begin
                            oh_d  = enc_oh;
                            idx_d = sel;
                        end
                    end
                end
                is_scan: begin
                    oh_d   = enc_oh;
                    idx_d  = idx_nxt;
                    step_d = adv;
                    cnt_d  = (entering | at_end) ? '0
                                                 : cnt_q + CW'(1);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oh_q   <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            scan_q <= 1'b0;
            step_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            oh_q   <= oh_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            scan_q <= scan_d;
            step_q <= step_d;
            err_q  <= err_d;
        end
    end

    assign sel_ready = en & (mode_s == MODE_DECODE);
    assign out       = (ACTIVE_LOW != 0) ? ~oh_q : oh_q;
    assign idx       = idx_q;
    assign step      = step_q & en;
    assign err       = err_q & en;

endmodule

// File: tb/tb_dec_onehot_scan.sv
// Directed bench for dec_onehot_scan across four parameter sets.
// All instances share stimulus; each scenario checks one of them.
module tb_dec_onehot_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [3:0] sel;
    logic       sel_valid;

    logic        rdy0, rdy1, rdy2, rdy3;
    logic [15:0] out0, out2, out3;
    logic [9:0]  out1;
    logic [3:0]  idx0, idx1, idx2, idx3;
    logic        step0, step1, step2, step3;
    logic        err0, err1, err2, err3;

    integer n_chk  = 0;
    integer n_fail = 0;

    always #5 clk = ~clk;

    dec_onehot_scan #(.N(4), .OUTS(16), .DWELL(3), .ACTIVE_LOW(0)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
        .sel_valid(sel_valid), .sel_ready(rdy0), .out(out0), .idx(idx0),
        .step(step0), .err(err0)
    );

    dec_onehot_scan #(.N(4), .OUTS(10), .DWELL(3), .ACTIVE_LOW(0)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
        .sel_valid(sel_valid), .sel_ready(rdy1), .out(out1), .idx(idx1),
        .step(step1), .err(err1)
    );

    dec_onehot_scan #(.N(4), .OUTS(16), .DWELL(2), .ACTIVE_LOW(0)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
        .sel_valid(sel_valid), .sel_ready(rdy2), .out(out2), .idx(idx2),
        .step(step2), .err(err2)
    );

    dec_onehot_scan #(.N(4), .OUTS(16), .DWELL(3), .ACTIVE_LOW(1)) u3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
        .sel_valid(sel_valid), .sel_ready(rdy3), .out(out3), .idx(idx3),
        .step(step3), .err(err3)
    );

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; mode = 2'b00;
        sel = 4'd0; sel_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (out0 !== 16'h0000) begin
            n_fail++; $display("FAIL rst_out: got %h want 0000", out0);
        end
        n_chk++;
        if (idx0 !== 4'd0) begin
            n_fail++; $display("FAIL rst_idx: got %0d want 0", idx0);
        end
        n_chk++;
        if (step0 !== 1'b0 || err0 !== 1'b0) begin
            n_fail++; $display("FAIL rst_pulses: got %b%b want 00", step0, err0);
        end
        n_chk++;
        if (out3 !== 16'hFFFF) begin
            n_fail++; $display("FAIL rst_out_al: got %h want FFFF", out3);
        end
        n_chk++;
        if (rdy0 !== 1'b0) begin
            n_fail++; $display("FAIL rst_ready: got %b want 0", rdy0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        mode = 2'b01; sel = 4'b1011; sel_valid = 1'b1;
        #1;
        n_chk++;
        if (rdy0 !== 1'b1) begin
            n_fail++; $display("FAIL dec_ready: got %b want 1", rdy0);
        end
        @(negedge clk);
        sel_valid = 1'b0;
        n_chk++;
        if (out0 !== 16'h0800) begin
            n_fail++; $display("FAIL dec_out: got %h want 0800", out0);
        end
        n_chk++;
        if (idx0 !== 4'd11) begin
            n_fail++; $display("FAIL dec_idx: got %0d want 11", idx0);
        end
        n_chk++;
        if (err0 !== 1'b0) begin
            n_fail++; $display("FAIL dec_err: got %b want 0", err0);
        end
        @(negedge clk);
        n_chk++;
        if (out0 !== 16'h0800) begin
            n_fail++; $display("FAIL dec_hold: got %h want 0800", out0);
        end
    endtask

    task automatic test_out_of_range();
        sel = 4'd3; sel_valid = 1'b1;
        @(negedge clk);
        sel_valid = 1'b0;
        n_chk++;
        if (out1 !== 10'h008 || idx1 !== 4'd3) begin
            n_fail++; $display("FAIL oor_pre: got %h/%0d want 008/3", out1, idx1);
        end
        sel = 4'd12; sel_valid = 1'b1;
        @(negedge clk);
        sel_valid = 1'b0;
        n_chk++;
        if (out1 !== 10'h000) begin
            n_fail++; $display("FAIL oor_out: got %h want 000", out1);
        end
        n_chk++;
        if (err1 !== 1'b1) begin
            n_fail++; $display("FAIL oor_err: got %b want 1", err1);
        end
        n_chk++;
        if (idx1 !== 4'd3) begin
            n_fail++; $display("FAIL oor_idx: got %0d want 3", idx1);
        end
        n_chk++;
        if (out0 !== 16'h1000) begin
            n_fail++; $display("FAIL oor_wide: got %h want 1000", out0);
        end
        @(negedge clk);
        n_chk++;
        if (err1 !== 1'b0 || out1 !== 10'h000) begin
            n_fail++; $display("FAIL oor_after: got %b/%h want 0/000", err1, out1);
        end
    endtask

    task automatic test_scan_up();
        int          ei [10];
        logic        es [10];
        logic [15:0] eo;
        ei = '{14, 14, 14, 15, 15, 15, 0, 0, 0, 1};
        es = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
        sel = 4'd14; sel_valid = 1'b1;
        @(negedge clk);
        sel_valid = 1'b0;
        n_chk++;
        if (idx0 !== 4'd14 || out0 !== 16'h4000) begin
            n_fail++; $display("FAIL up_seed: got %0d/%h want 14/4000", idx0, out0);
        end
        mode = 2'b10;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            eo = 16'h0001 << ei[k];
            n_chk++;
            if (idx0 !== 4'(ei[k]) || step0 !== es[k] || out0 !== eo) begin
                n_fail++;
                $display("FAIL up_c%0d: got %0d/%b/%h want %0d/%b/%h",
                         k, idx0, step0, out0, ei[k], es[k], eo);
            end
        end
    endtask

    task automatic test_scan_down();
        int   ei [5];
        logic es [5];
        ei = '{0, 0, 15, 15, 14};
        es = '{0, 0, 1, 0, 1};
        mode = 2'b01; sel = 4'd0; sel_valid = 1'b1;
        @(negedge clk);
        sel_valid = 1'b0;
        n_chk++;
        if (idx2 !== 4'd0) begin
            n_fail++; $display("FAIL dn_seed: got %0d want 0", idx2);
        end
        mode = 2'b11;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_chk++;
            if (idx2 !== 4'(ei[k]) || step2 !== es[k]) begin
                n_fail++;
                $display("FAIL dn_c%0d: got %0d/%b want %0d/%b",
                         k, idx2, step2, ei[k], es[k]);
            end
        end
        mode = 2'b10;
        @(negedge clk);
        n_chk++;
        if (idx2 !== 4'd14 || step2 !== 1'b0) begin
            n_fail++; $display("FAIL sw_mid: got %0d/%b want 14/0", idx2, step2);
        end
        @(negedge clk);
        n_chk++;
        if (idx2 !== 4'd15 || step2 !== 1'b1 || out2 !== 16'h8000) begin
            n_fail++;
            $display("FAIL sw_adv: got %0d/%b/%h want 15/1/8000", idx2, step2, out2);
        end
    endtask

    task automatic test_freeze();
        en = 1'b0;
        #1;
        n_chk++;
        if (step2 !== 1'b0) begin
            n_fail++; $display("FAIL frz_gate: got %b want 0", step2);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_chk++;
            if (idx2 !== 4'd15 || step2 !== 1'b0 || out2 !== 16'h8000) begin
                n_fail++;
                $display("FAIL frz_c%0d: got %0d/%b/%h want 15/0/8000",
                         k, idx2, step2, out2);
            end
        end
        en = 1'b1;
        @(negedge clk);
        n_chk++;
        if (idx2 !== 4'd15 || step2 !== 1'b0) begin
            n_fail++; $display("FAIL frz_res1: got %0d/%b want 15/0", idx2, step2);
        end
        @(negedge clk);
        n_chk++;
        if (idx2 !== 4'd0 || step2 !== 1'b1 || out2 !== 16'h0001) begin
            n_fail++;
            $display("FAIL frz_res2: got %0d/%b/%h want 0/1/0001", idx2, step2, out2);
        end
    endtask

    task automatic test_async_reset();
        repeat (2) @(negedge clk);
        n_chk++;
        if (idx2 !== 4'd1) begin
            n_fail++; $display("FAIL ar_pre: got %0d want 1", idx2);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (out2 !== 16'h0000 || idx2 !== 4'd0) begin
            n_fail++; $display("FAIL ar_now: got %h/%0d want 0000/0", out2, idx2);
        end
        n_chk++;
        if (out3 !== 16'hFFFF || step2 !== 1'b0) begin
            n_fail++; $display("FAIL ar_misc: got %h/%b want FFFF/0", out3, step2);
        end
        mode = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_polarity();
        mode = 2'b01; sel = 4'd0; sel_valid = 1'b1;
        @(negedge clk);
        sel_valid = 1'b0;
        n_chk++;
        if (out3 !== 16'hFFFE) begin
            n_fail++; $display("FAIL pol_dec: got %h want FFFE", out3);
        end
        sel = 4'd5; sel_valid = 1'b1;
        @(negedge clk);
        sel_valid = 1'b0;
        mode = 2'b00;
        @(negedge clk);
        n_chk++;
        if (out3 !== 16'hFFFF) begin
            n_fail++; $display("FAIL pol_idle: got %h want FFFF", out3);
        end
        n_chk++;
        if (out0 !== 16'h0000 || idx0 !== 4'd5) begin
            n_fail++; $display("FAIL idle_hold: got %h/%0d want 0000/5", out0, idx0);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_out_of_range();
        test_scan_up();
        test_scan_down();
        test_freeze();
        test_async_reset();
        test_polarity();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
